axi_wr_slave_mem: RTL
=====================

Name: axi_wr_slave_mem

Overview:
- AXI write-channel responder: the slave end of the write address, write data and write response channels, backed by an internal 64-bit-word memory.
- Accepts one burst at a time (AW, then AWLEN+1 W beats), stores data, returns one B response.
- Used as the write target for master-side blocks and as a bench memory model.
- Debug read port exposes memory contents for checking.

Parameters:
DEPTH  256  memory depth in 64-bit words; power of 2, 2..2^29; byte address range 0..DEPTH*8-1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (rst=0 resets)
AWID  input  4  write burst ID
AWADDR  input  32  byte start address
AWLEN  input  4  beats-1 (1..16 beats)
AWSIZE  input  3  beat size; only 3'b011 (8 bytes) supported
AWBURST  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWLOCK  input  2  ignored
AWCACHE  input  2  ignored
AWPROT  input  3  ignored
AWVALID  input  1  address valid
AWREADY  output  1  address ready
WID  input  4  write data ID
WDATA  input  64  write data
WLAST  input  1  last beat flag
WVALID  input  1  data valid
WREADY  output  1  data ready
BID  output  4  response ID (= captured AWID)
BRESP  output  2  00 OKAY, 10 SLVERR, 11 DECERR
BUSER  output  1  tied 0
BVALID  output  1  response valid
BREADY  input  1  response ready
dbg_addr  input  log2(DEPTH)  debug word index
dbg_data  output  64  mem[dbg_addr], registered, 1-cycle latency
busy  output  1  high when FSM is not in IDLE

Behaviour:
- Reset (rst=0, async): FSM=IDLE; AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, BUSER=0, busy=0, dbg_data=0.
- Memory is not reset. Reset mid-burst aborts the burst, keeps beats already written, and emits no B.
- First cycle after reset release: AWREADY=1.
- FSM IDLE: AWREADY=1.
  - On AWVALID&AWREADY at edge T: capture AWID, word index, AWLEN, AWBURST; compute err code; go to DATA.
  - In DATA at T+1: AWREADY=0, WREADY=1.
- FSM DATA: WREADY=1.
  - Each WVALID&WREADY writes WDATA to mem[idx] at that edge, suppressed if err!=OKAY.
  - Beat counter increments; idx advances.
  - Beat AWLEN+1 accepted at edge T': go to RESP; BVALID=1 from T'+1. WREADY=0 from T'+1.
  - Burst ends by beat count only, never by WLAST.
- FSM RESP: BVALID=1 holding BID/BRESP stable until BREADY.
  - Handshake at edge: BVALID=0, go to IDLE, AWREADY=1 next cycle.
  - Minimum per burst: 1 AW cycle + N beat cycles + 1 B cycle. No overlap between bursts.
- Address: idx = AWADDR[3+:log2(DEPTH)]. AWADDR[2:0] ignored.
  - FIXED: idx constant.
  - INCR: idx+1 per beat.
  - WRAP: idx+1 within an aligned block of AWLEN+1 words; low log2(AWLEN+1) bits wrap, upper bits held.
- Error priority, computed at AW accept (highest first):
  - DECERR: INCR with AWADDR>>3 + AWLEN > DEPTH-1, or any burst with AWADDR >= DEPTH*8.
  - SLVERR: AWSIZE!=3, AWBURST=11, or WRAP with AWLEN not in {1,3,7,15}.
  - Both DECERR and SLVERR suppress all writes of the burst; beats are still accepted.
- Per-beat SLVERR: WID!=captured AWID, or WLAST=1 on a non-final beat, or WLAST=0 on the final beat.
  - Sets a sticky SLVERR unless already DECERR.
  - Data is still written if the address phase was OKAY.
- Simultaneous events:
  - AWVALID during DATA/RESP is ignored (held off by AWREADY=0).
  - WVALID in IDLE/RESP is not accepted.
- Debug read: dbg_data <= mem[dbg_addr] each edge. A write and a read to the same index at the same edge returns old data.

Test Plan:
- INCR, AWADDR=0x10, AWLEN=3, AWSIZE=3, AWID=5, WDATA=A0..A3 with WLAST on beat 4 -> mem[2..5]=A0..A3; BID=5, BRESP=00; BVALID one cycle after 4th beat.
- WRAP, AWADDR=0x30 (idx 6), AWLEN=3, data D0..D3 -> mem[6]=D0, mem[7]=D1, mem[4]=D2, mem[5]=D3; BRESP=00.
- FIXED, AWADDR=0x08, AWLEN=2, data 1,2,3 -> mem[1]=3; INCR AWADDR=(DEPTH-2)*8, AWLEN=3 -> 4 beats accepted, no writes, BRESP=11.
- AWSIZE=2 or WID mismatch on beat 2 or WLAST early -> BRESP=10 after AWLEN+1 beats; WID/WLAST cases still write data.
- BREADY held low 5 cycles -> BVALID, BID, BRESP stable; AWREADY=0 throughout; AWREADY=1 the cycle after handshake.
- rst=0 asserted after 2 of 4 beats -> outputs 0 immediately; no BVALID after release; 2 beats present in mem; next burst completes normally.

Source files
------------

// File: rtl/axi_wr_if.sv
// AXI write-channel bundle (AW, W, B) shared by a write master and the write slave memory.
interface axi_wr_if;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [1:0]  AWLOCK;
  logic [1:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [3:0]  WID;
  logic [63:0] WDATA;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BUSER;
  logic        BVALID;
  logic        BREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    output AWREADY,
    input  WID, WDATA, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BUSER, BVALID,
    input  BREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    input  AWREADY,
    output WID, WDATA, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BUSER, BVALID,
    output BREADY
  );
endinterface

// File: rtl/axi_wr_slave_mem.sv
// AXI write slave: accepts one burst at a time into a 64-bit word memory and returns one B response.
// Memory contents survive reset; a registered debug port reads any word.
module axi_wr_slave_mem #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  axi_wr_if.slave                    axi,
  input  logic [$clog2(DEPTH)-1:0]   dbg_addr,
  output logic [63:0]                dbg_data,
  output logic                       busy
);
  localparam int unsigned IW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) * 33'd8;
  localparam logic [32:0] WORD_MAX   = 33'(DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    id_q, id_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    len_q, len_d;
  logic [1:0]    burst_q, burst_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    err_q, err_d;
  logic          wr_ok_q, wr_ok_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [3:0]    bid_q, bid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          busy_q, busy_d;
  logic [63:0]   dbg_data_q, dbg_data_d;

  logic [63:0]   mem [DEPTH];
  logic          mem_we_c;
  logic [IW-1:0] aw_idx_c;
  logic          aw_decerr_c, aw_slverr_c;
  logic [IW-1:0] wrap_mask_c, idx_nx_c;
  logic          beat_last_c, beat_bad_c;
  logic          unused_c;

  assign unused_c = ^{axi.AWLOCK, axi.AWCACHE, axi.AWPROT};

  // Address-phase decode: word index and error class of the offered burst
  always_comb begin
    aw_idx_c    = axi.AWADDR[3 +: IW];
    aw_decerr_c = ({1'b0, axi.AWADDR} >= BYTE_LIMIT) ||
                  ((axi.AWBURST == BURST_INCR) &&
                   ((33'(axi.AWADDR[31:3]) + 33'(axi.AWLEN)) > WORD_MAX));
    aw_slverr_c = (axi.AWSIZE != 3'b011) || (axi.AWBURST == BURST_RSVD) ||
                  ((axi.AWBURST == BURST_WRAP) &&
                   !(axi.AWLEN inside {4'd1, 4'd3, 4'd7, 4'd15}));
  end

  // Next word index; WRAP lengths are 2^k-1, so len_q doubles as the wrap mask
  always_comb begin
    wrap_mask_c = IW'(len_q);
    idx_nx_c    = idx_q;
    case (burst_q)
      BURST_INCR: idx_nx_c = idx_q + IW'(1);
      BURST_WRAP: idx_nx_c = (idx_q & ~wrap_mask_c) | ((idx_q + IW'(1)) & wrap_mask_c);
      default:    idx_nx_c = idx_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    idx_d      = idx_q;
    len_d      = len_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    wr_ok_d    = wr_ok_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    mem_we_c   = 1'b0;
    dbg_data_d = mem[dbg_addr];
    beat_last_c = (cnt_q == len_q);
    beat_bad_c  = (axi.WID != id_q) || (axi.WLAST != beat_last_c);

    case (state_q)
      S_IDLE: begin
        if (axi.AWVALID && awready_q) begin
          id_d    = axi.AWID;
          idx_d   = aw_idx_c;
          len_d   = axi.AWLEN;
          burst_d = axi.AWBURST;
          cnt_d   = 4'd0;
          err_d   = aw_decerr_c ? RESP_DECERR : (aw_slverr_c ? RESP_SLVERR : RESP_OKAY);
          wr_ok_d = !aw_decerr_c && !aw_slverr_c;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (axi.WVALID && wready_q) begin
          mem_we_c = wr_ok_q;
          cnt_d    = cnt_q + 4'd1;
          idx_d    = idx_nx_c;
          // Protocol slips degrade to SLVERR but never mask a decode error
          if (beat_bad_c && (err_q != RESP_DECERR)) err_d = RESP_SLVERR;
          if (beat_last_c) begin
            bid_d   = id_q;
            bresp_d = err_d;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (axi.BREADY && bvalid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    awready_d = (state_d == S_IDLE);
    wready_d  = (state_d == S_DATA);
    bvalid_d  = (state_d == S_RESP);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      id_q       <= 4'd0;
      idx_q      <= '0;
      len_q      <= 4'd0;
      burst_q    <= 2'd0;
      cnt_q      <= 4'd0;
      err_q      <= RESP_OKAY;
      wr_ok_q    <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= 4'd0;
      bresp_q    <= RESP_OKAY;
      busy_q     <= 1'b0;
      dbg_data_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      wr_ok_q    <= wr_ok_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      busy_q     <= busy_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  // Storage is deliberately outside reset so an aborted burst keeps its beats
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_q] <= axi.WDATA;
  end

  assign axi.AWREADY = awready_q;
  assign axi.WREADY  = wready_q;
  assign axi.BVALID  = bvalid_q;
  assign axi.BID     = bid_q;
  assign axi.BRESP   = bresp_q;
  assign axi.BUSER   = 1'b0;
  assign dbg_data    = dbg_data_q;
  assign busy        = busy_q;
endmodule
